// File: rtl/fft_pkg.sv
// Shared FFT front-end constants, sample/beat types, read-FSM encoding and bitrev4 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int DATA_W = 34;   // complex sample: [33:17] real, [16:0] imag
    localparam int LANES  = 4;    // samples per output beat
    localparam int FFT_N  = 16;   // samples per frame
    localparam int IDX_W  = 4;    // log2(FFT_N)
    localparam int BEAT_W = 2;    // log2(FFT_N / LANES)

    typedef logic [DATA_W-1:0]       sample_t;
    typedef logic [LANES*DATA_W-1:0] beat_t;
    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [BEAT_W-1:0]       beat_idx_t;

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_0    = 3'd1,
        RD_1    = 3'd2,
        RD_2    = 3'd3,
        RD_3    = 3'd4
    } rd_state_t;

    // Reverse the four bits of a frame index.
    function automatic idx_t bitrev4(input idx_t i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

endpackage

// File: rtl/s_p_bank.sv
// One ping-pong bank: 16 x 34 register file, one write port, four parallel read lanes.
// Latency: write visible the cycle after the write edge; reads are combinational.
// Backpressure: none; the owner gates we.
// Ports: clk; we/waddr/wdata write port; beat selects which four samples appear on rdata.
// Lane l of rdata carries sample 4l+beat, or bitrev4(4l+beat) when S_P_BITREV_EN is defined.
// Storage is deliberately not reset: a bank is only read after a full frame has been written.
module s_p_bank
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  idx_t            waddr,
    input  sample_t         wdata,
    input  beat_idx_t       beat,
    output beat_t           rdata
);

    sample_t mem [FFT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        idx_t lin;
        // Linear index 4l+beat: lane number in the upper bits, beat in the lower bits.
        assign lin = {BEAT_W'(l), beat};
`ifdef S_P_BITREV_EN
        assign rdata[l*DATA_W +: DATA_W] = mem[bitrev4(lin)];
`else
        assign rdata[l*DATA_W +: DATA_W] = mem[lin];
`endif
    end

endmodule

// File: rtl/s_p_reorder.sv
// Serial-to-parallel reorder: 16 serial samples per frame out as four 4-lane beats.
// Latency: beat 0 registered one cycle after the edge accepting index 15; beats 1-3 follow.
// Backpressure: none; readout (4 cycles) always beats the next fill (16 cycles).
// Ports: clk, rst_n (async active-low); data_in_1/s_p_flag_in/frame_sync serial input;
//        data_out_1/s_p_flag_out beat output; frame_drop pulses when a partial frame is discarded.
// Option: S_P_BITREV_EN selects bit-reversed lane ordering inside s_p_bank.
module s_p_reorder
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         data_in_1,
    input  logic                      s_p_flag_in,
    input  logic                      frame_sync,
    output logic [LANES*DATA_W-1:0]   data_out_1,
    output logic                      s_p_flag_out,
    output logic                      frame_drop
);

    idx_t       wr_cnt;
    logic       wr_bank;
    logic       rd_bank;
    idx_t       waddr;
    logic       sync;
    logic       frame_done;
    rd_state_t  state;
    rd_state_t  state_nxt;
    logic       emit;
    beat_idx_t  beat;
    beat_t      bank0_rdata;
    beat_t      bank1_rdata;
    beat_t      rd_dat;

    // A sync sample restarts the frame at index 0 regardless of the current count.
    assign sync       = s_p_flag_in & frame_sync;
    assign waddr      = sync ? '0 : wr_cnt;
    assign frame_done = s_p_flag_in & (waddr == idx_t'(FFT_N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= sync & (wr_cnt != '0);
            if (s_p_flag_in) begin
                wr_cnt <= waddr + 1'b1;   // wraps 15 -> 0
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                    rd_bank <= wr_bank;   // the bank just filled becomes the read bank
                end
            end
        end
    end

    s_p_bank u_bank0 (
        .clk   (clk),
        .we    (s_p_flag_in & ~wr_bank),
        .waddr (waddr),
        .wdata (data_in_1),
        .beat  (beat),
        .rdata (bank0_rdata)
    );

    s_p_bank u_bank1 (
        .clk   (clk),
        .we    (s_p_flag_in & wr_bank),
        .waddr (waddr),
        .wdata (data_in_1),
        .beat  (beat),
        .rdata (bank1_rdata)
    );

    assign rd_dat = rd_bank ? bank1_rdata : bank0_rdata;

    // Read FSM: RDj means "register beat j at the next edge".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: state_nxt = frame_done ? RD_0 : RD_IDLE;
            RD_0:    state_nxt = RD_1;
            RD_1:    state_nxt = RD_2;
            RD_2:    state_nxt = RD_3;
            RD_3:    state_nxt = frame_done ? RD_0 : RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        emit = 1'b0;
        beat = '0;
        case (state)
            RD_0:    begin emit = 1'b1; beat = 2'd0; end
            RD_1:    begin emit = 1'b1; beat = 2'd1; end
            RD_2:    begin emit = 1'b1; beat = 2'd2; end
            RD_3:    begin emit = 1'b1; beat = 2'd3; end
            default: begin emit = 1'b0; beat = '0;   end
        endcase
    end

    // Output register holds its last beat while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_1   <= '0;
            s_p_flag_out <= 1'b0;
        end else begin
            s_p_flag_out <= emit;
            if (emit) begin
                data_out_1 <= rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_s_p_reorder.sv
// Directed bench for s_p_reorder with a scoreboard of expected beats and their cycles.
// Latency: n/a.
// Backpressure: n/a.
module tb_s_p_reorder;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [33:0]    data_in_1 = '0;
    logic           s_p_flag_in = 1'b0;
    logic           frame_sync = 1'b0;
    logic [135:0]   data_out_1;
    logic           s_p_flag_out;
    logic           frame_drop;

    s_p_reorder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_1    (data_in_1),
        .s_p_flag_in  (s_p_flag_in),
        .frame_sync   (frame_sync),
        .data_out_1   (data_out_1),
        .s_p_flag_out (s_p_flag_out),
        .frame_drop   (frame_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [135:0] dat;
        int           at;
    } exp_t;

    exp_t         sbq[$];
    logic [33:0]  mbuf [16];
    int           mcnt = 0;
    int           exp_drop = -1;
    logic [135:0] last_out = '0;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = x[3-i];
        return r;
    endfunction

    function automatic logic [3:0] src_idx(input int l, input int j);
        logic [3:0] n;
        n = 4'(4 * l + j);
`ifdef S_P_BITREV_EN
        return rev4(n);
`else
        return n;
`endif
    endfunction

    // Frame completed at the edge where cyc became cap: beat j visible while cyc == cap+1+j.
    task automatic push_frame(input int cap);
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            e.dat = '0;
            for (int l = 0; l < 4; l++) e.dat[34*l +: 34] = mbuf[src_idx(l, j)];
            e.at = cap + 1 + j;
            sbq.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input logic [33:0] d, input bit s);
        s_p_flag_in = v;
        data_in_1   = d;
        frame_sync  = s;
        @(posedge clk);
        #1;
        if (v) begin
            if (s) begin
                if (mcnt != 0) exp_drop = cyc;
                mcnt = 0;
            end
            mbuf[mcnt] = d;
            if (mcnt == 15) push_frame(cyc);
            mcnt = (mcnt + 1) % 16;
        end
        s_p_flag_in = 1'b0;
        frame_sync  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 64) begin
            drive(1'b0, '0, 1'b0);
            n++;
        end
        repeat (3) drive(1'b0, '0, 1'b0);
        chk(tag, 136'(sbq.size()), 136'd0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (s_p_flag_out) begin
                if (sbq.size() == 0) begin
                    chk("spurious_beat", 136'(s_p_flag_out), 136'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_dat", data_out_1, e.dat);
                    chk("beat_cyc", 136'(cyc), 136'(e.at));
                    last_out = e.dat;
                end
            end else begin
                chk("hold", data_out_1, last_out);
                if (sbq.size() != 0 && sbq[0].at <= cyc) begin
                    chk("missing_beat", 136'(s_p_flag_out), 136'd1);
                    void'(sbq.pop_front());
                end
            end
            if (frame_drop || cyc == exp_drop)
                chk("frame_drop", 136'(frame_drop), 136'(cyc == exp_drop));
        end
    end

    initial begin
        int c;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flag", 136'(s_p_flag_out), 136'd0);
        chk("rst_dat", data_out_1, 136'd0);
        chk("rst_drop", 136'(frame_drop), 136'd0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, '0, 1'b0);

        // Ramp 0x0..0xF, contiguous
        for (int i = 0; i < 16; i++) drive(1'b1, 34'(i), 1'b0);
        drain("drain_ramp");

        // Three back-to-back frames, valid high for 48 cycles
        for (int i = 0; i < 48; i++) drive(1'b1, 34'({$urandom(), $urandom()}), 1'b0);
        drain("drain_b2b");

        // Valid toggling every cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 34'(i), 1'b0);
            drive(1'b0, 34'h3_FFFF_FFFF, 1'b1);   // sync without valid is ignored
        end
        drain("drain_toggle");

        // Sync at index 7: partial frame dropped, then a full frame
        for (int i = 0; i < 7; i++) drive(1'b1, 34'(100 + i), 1'b0);
        drive(1'b1, 34'h2_0000_0000, 1'b1);
        for (int i = 1; i < 16; i++) drive(1'b1, 34'h2_0000_0000 + 34'(i), 1'b0);
        drain("drain_sync");

        // Reset during beat 2
        for (int i = 0; i < 16; i++) drive(1'b1, 34'(200 + i), 1'b0);
        c = cyc;
        while (cyc < c + 3) drive(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_flag", 136'(s_p_flag_out), 136'd0);
        chk("abort_dat", data_out_1, 136'd0);
        sbq.delete();
        mcnt = 0;
        exp_drop = -1;
        last_out = '0;
        @(posedge clk);
        #1;
        chk("abort_hold_flag", 136'(s_p_flag_out), 136'd0);
        rst_n = 1'b1;
        repeat (6) drive(1'b0, '0, 1'b0);

        // Recovery after reset: only a complete frame produces output
        for (int i = 0; i < 16; i++) drive(1'b1, 34'(300 + i), 1'b0);
        drain("drain_recover");

        chk("sb_empty", 136'(sbq.size()), 136'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
